// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan display: the active-low hex glyph table
// and the all-dark patterns for segments and digit enables.
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Active-low gfedcba glyphs, indexed by nibble value 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_display_if.sv
// Bundle between the CPU top (master) and the scanned display stage (slave):
// the words and flags to show, and the pins driving the board's digits and LEDs.
interface seg_scan_display_if;

  logic [31:0] F;
  logic [31:0] M_R_Data;
  logic        ZF;
  logic        OF;
  logic        sel;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic [1:0]  led;

  modport master (
    output F, M_R_Data, ZF, OF, sel,
    input  an, seg, led
  );

  modport slave (
    input  F, M_R_Data, ZF, OF, sel,
    output an, seg, led
  );

endinterface

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low gfedcba glyph lookup.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexes one captured 32-bit word as 8 hex digits on a common-anode
// 7-segment array; the word and flags are captured only at frame wrap so a frame never tears.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIV      = 100_000,
  parameter bit BLANK_LZ = 1'b0
)
(
  input  logic               clk_100MHz,
  input  logic               rst,
  seg_scan_display_if.slave  bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   snap;

  logic          tick;
  logic          wrap;
  logic [2:0]    idx_next;
  logic [31:0]   snap_next;
  logic [31:0]   upper;
  logic [3:0]    nibble;
  logic [6:0]    pattern;
  logic          blank;

  assign tick      = (presc == PW'(DIV - 1));
  assign wrap      = (idx == 3'd7);
  assign idx_next  = idx + 3'd1;
  assign snap_next = wrap ? (bus.sel ? bus.M_R_Data : bus.F) : snap;
  assign nibble    = snap_next[{idx_next, 2'b00} +: 4];

  // A digit is a leading zero when it and every more significant nibble are zero.
  assign upper = snap_next >> {idx_next, 2'b00};
  assign blank = BLANK_LZ && (idx_next != 3'd0) && (upper == 32'd0);

  hex_to_seg u_hex_to_seg (
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // idx resets to 7 so the first tick wraps, captures a frame and lights digit 0.
  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      idx     <= 3'd7;
      snap    <= 32'd0;
      bus.an  <= AN_OFF;
      bus.seg <= SEG_BLANK;
      bus.led <= 2'b00;
    end else if (tick) begin
      idx <= idx_next;
      if (wrap) begin
        snap    <= snap_next;
        bus.led <= {bus.OF, bus.ZF};
      end
      bus.an  <= ~(8'b1 << idx_next);
      bus.seg <= blank ? SEG_BLANK : {1'b1, pattern};
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized and directed bench for seg_scan_display with DIV=4, running one DUT
// per leading-zero mode against a cycle-count based reference model.
module tb_seg_scan_display;

  localparam int DIV = 4;

  localparam logic [6:0] HEX_MAP [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [7:0] AN_WALK [8] = '{
    8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F
  };
  localparam logic [6:0] SEG_WALK [8] = '{
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00
  };
  localparam logic [7:0] LZ_SEG [8] = '{
    8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

  logic        clk;
  logic        rst;
  logic [31:0] f;
  logic [31:0] mrd;
  logic        zf;
  logic        of;
  logic        sel;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  seg_scan_display_if bus0 ();
  seg_scan_display_if bus1 ();

  assign bus0.F = f;
  assign bus0.M_R_Data = mrd;
  assign bus0.ZF = zf;
  assign bus0.OF = of;
  assign bus0.sel = sel;
  assign bus1.F = f;
  assign bus1.M_R_Data = mrd;
  assign bus1.ZF = zf;
  assign bus1.OF = of;
  assign bus1.sel = sel;

  seg_scan_display #(.DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
    .clk_100MHz (clk),
    .rst        (rst),
    .bus        (bus0)
  );

  seg_scan_display #(.DIV(DIV), .BLANK_LZ(1'b1)) dut1 (
    .clk_100MHz (clk),
    .rst        (rst),
    .bus        (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] fv, input logic [31:0] mv,
                               input logic s, input logic z, input logic o);
    f   = fv;
    mrd = mv;
    sel = s;
    zf  = z;
    of  = o;
  endtask

  // Expected segment byte for digit k of a word, from nibble arithmetic.
  function automatic logic [7:0] refSeg(input logic [31:0] word, input int k, input bit blankLz);
    longint unsigned w;
    longint unsigned scale;
    w = word;
    scale = 64'd1 << (4 * k);
    if (blankLz && k > 0 && (w / scale) == 0) return 8'hFF;
    return {1'b1, HEX_MAP[int'((w / scale) % 16)]};
  endfunction

  // Digit shown after edge number c+1 since reset release, when that edge is a slot boundary.
  function automatic int slotDigit(input int c);
    return ((c + 1) / DIV - 1) % 8;
  endfunction

  int          cyc;
  logic [31:0] mSnap;
  logic [1:0]  mLed;
  logic [7:0]  mAn;
  logic [7:0]  mSeg0;
  logic [7:0]  mSeg1;

  // Reference: every DIV edges after release a new slot begins; slot 0 of each frame captures.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc   <= 0;
      mSnap <= 32'd0;
      mLed  <= 2'b00;
      mAn   <= 8'hFF;
      mSeg0 <= 8'hFF;
      mSeg1 <= 8'hFF;
    end else begin
      cyc <= cyc + 1;
      if ((cyc + 1) % DIV == 0) begin
        mAn <= ~(8'd1 << slotDigit(cyc));
        if (slotDigit(cyc) == 0) begin
          mSnap <= sel ? mrd : f;
          mLed  <= {of, zf};
          mSeg0 <= refSeg(sel ? mrd : f, 0, 1'b0);
          mSeg1 <= refSeg(sel ? mrd : f, 0, 1'b1);
        end else begin
          mSeg0 <= refSeg(mSnap, slotDigit(cyc), 1'b0);
          mSeg1 <= refSeg(mSnap, slotDigit(cyc), 1'b1);
        end
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (checkEn) begin
      checkOutput("an0", bus0.an, mAn);
      checkOutput("seg0", bus0.seg, mSeg0);
      checkOutput("led0", bus0.led, mLed);
      checkOutput("an1", bus1.an, mAn);
      checkOutput("seg1", bus1.seg, mSeg1);
      checkOutput("led1", bus1.led, mLed);
    end
  end

  task automatic checkRestart();
    for (int i = 0; i < DIV - 1; i++) begin
      @(negedge clk);
      checkOutput("anDark", bus0.an, 8'hFF);
      checkOutput("segDark", bus0.seg, 8'hFF);
    end
    @(negedge clk);
    checkOutput("anFirst", bus0.an, 8'hFE);
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(32'h89AB_CDEF, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rstAn", bus0.an, 8'hFF);
    checkOutput("rstSeg", bus0.seg, 8'hFF);
    checkOutput("rstLed", bus0.led, 2'b00);
    checkEn = 1;
    rst = 1'b1;
    checkRestart();

    for (int i = 0; i < 8; i++) begin
      checkOutput("walkAn", bus0.an, AN_WALK[i]);
      checkOutput("walkSeg", bus0.seg, {1'b1, SEG_WALK[i]});
      repeat (DIV) @(negedge clk);
    end

    repeat (3 * DIV) @(negedge clk);
    applyStimulus(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (DIV) @(negedge clk);
    for (int i = 4; i < 8; i++) begin
      checkOutput("noTear", bus0.seg, {1'b1, SEG_WALK[i]});
      repeat (DIV) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput("zeroFrame", bus0.seg, 8'hC0);
      repeat (DIV) @(negedge clk);
    end

    applyStimulus(32'd0, 32'h0000_0012, 1'b0, 1'b0, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    applyStimulus(32'd0, 32'h0000_0012, 1'b1, 1'b1, 1'b1);
    for (int i = 2; i < 8; i++) begin
      checkOutput("ledHold", bus0.led, 2'b00);
      checkOutput("selHold", bus0.seg, 8'hC0);
      repeat (DIV) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput("ledWrap", bus0.led, 2'b11);
      checkOutput("lzAn", bus1.an, AN_WALK[i]);
      checkOutput("lzSeg", bus1.seg, LZ_SEG[i]);
      repeat (DIV) @(negedge clk);
    end

    repeat (5 * DIV) @(negedge clk);
    checkOutput("preRstAn", bus0.an, 8'hDF);
    rst = 1'b0;
    #1;
    checkOutput("midRstAn", bus0.an, 8'hFF);
    checkOutput("midRstSeg", bus0.seg, 8'hFF);
    checkOutput("midRstLed", bus0.led, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    checkRestart();

    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 10) begin
        applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r < 16) begin
        applyStimulus($urandom >> $urandom_range(0, 31), $urandom >> $urandom_range(0, 31),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r == 19) begin
        rst = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst = 1'b1;
      end
      repeat ($urandom_range(1, 16)) @(negedge clk);
    end

    @(negedge clk);
    #3;
    checkEn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
